// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: window geometry, element
// indexing and FSM state encoding.
package window_gen_3x3_pkg;

  localparam int WIN_SIZE  = 3;
  localparam int WIN_ELEMS = WIN_SIZE * WIN_SIZE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Row 0 is the top of the window, column 0 the left edge.
  function automatic int winIdx(input int row, input int col);
    return WIN_SIZE * row + col;
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_delay_mem.sv
// One image row of pixel storage: single clock, one write port and one
// combinational read port so a pixel can be read and overwritten in one cycle.
module line_delay_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 720,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  wrEn_i,
  input  logic [ADDR_WIDTH-1:0] wrAddr_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic [ADDR_WIDTH-1:0] rdAddr_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; the window logic ignores rows not yet written.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: keeps the two previous rows in line
// delays and emits one window per interior pixel position (valid/ready both sides).
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_WIDTH  = 10,
  parameter int ROW_WIDTH  = 9
) (
  input  logic                          WG_Clk,
  input  logic                          WG_Reset_InLow,
  input  logic                          WG_Start,
  input  logic                          WG_Pix_Valid,
  input  logic [DATA_WIDTH-1:0]         WG_Pix_Data,
  output logic                          WG_Pix_Ready,
  output logic                          WG_Win_Valid,
  output logic [WIN_ELEMS*DATA_WIDTH-1:0] WG_Win_Data,
  input  logic                          WG_Win_Ready,
  output logic                          WG_Busy,
  output logic                          WG_Done
);

  logic [1:0]            state_q, state_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic                  lastTaken_q, lastTaken_d;
  logic                  winValid_q, winValid_d;
  logic [DATA_WIDTH-1:0] win_q [WIN_ELEMS];
  logic [DATA_WIDTH-1:0] win_d [WIN_ELEMS];
  logic [DATA_WIDTH-1:0] lb0Rd, lb1Rd;
  logic                  pixReady, accept, winHandshake;

  assign pixReady     = (state_q == ST_RUN) && !(winValid_q && !WG_Win_Ready) && !lastTaken_q;
  assign accept       = WG_Pix_Valid && pixReady;
  assign winHandshake = winValid_q && WG_Win_Ready;

  // lb0 holds row r-1, lb1 holds row r-2; both shift down by one row on accept.
  line_delay_mem #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_WIDTH(COL_WIDTH)
  ) u_lineDelay0 (
    .clk_i   (WG_Clk),
    .wrEn_i  (accept),
    .wrAddr_i(col_q),
    .wrData_i(WG_Pix_Data),
    .rdAddr_i(col_q),
    .rdData_o(lb0Rd)
  );

  line_delay_mem #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_WIDTH(COL_WIDTH)
  ) u_lineDelay1 (
    .clk_i   (WG_Clk),
    .wrEn_i  (accept),
    .wrAddr_i(col_q),
    .wrData_i(lb0Rd),
    .rdAddr_i(col_q),
    .rdData_o(lb1Rd)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    lastTaken_d = lastTaken_q;
    winValid_d  = winValid_q;
    win_d       = win_q;

    case (state_q)
      ST_IDLE: begin
        if (WG_Start) begin
          state_d     = ST_RUN;
          col_d       = '0;
          row_d       = '0;
          lastTaken_d = 1'b0;
          winValid_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (winHandshake) begin
          winValid_d = 1'b0;
        end
        if (accept) begin
          for (int r = 0; r < WIN_SIZE; r++) begin
            win_d[winIdx(r, 0)] = win_q[winIdx(r, 1)];
            win_d[winIdx(r, 1)] = win_q[winIdx(r, 2)];
          end
          win_d[winIdx(0, 2)] = lb1Rd;
          win_d[winIdx(1, 2)] = lb0Rd;
          win_d[winIdx(2, 2)] = WG_Pix_Data;
          // The first two columns of each row only prime the window.
          if (row_q >= ROW_WIDTH'(2) && col_q >= COL_WIDTH'(2)) begin
            winValid_d = 1'b1;
          end
          if (col_q == COL_WIDTH'(IMG_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == ROW_WIDTH'(IMG_HEIGHT - 1)) begin
              lastTaken_d = 1'b1;
            end else begin
              row_d = row_q + ROW_WIDTH'(1);
            end
          end else begin
            col_d = col_q + COL_WIDTH'(1);
          end
        end
        if (winHandshake && lastTaken_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge WG_Clk or negedge WG_Reset_InLow) begin
    if (!WG_Reset_InLow) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      lastTaken_q <= 1'b0;
      winValid_q  <= 1'b0;
      win_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      lastTaken_q <= lastTaken_d;
      winValid_q  <= winValid_d;
      win_q       <= win_d;
    end
  end

  for (genvar i = 0; i < WIN_ELEMS; i++) begin : g_pack
    assign WG_Win_Data[DATA_WIDTH*i +: DATA_WIDTH] = win_q[i];
  end

  assign WG_Pix_Ready = pixReady;
  assign WG_Win_Valid = winValid_q;
  assign WG_Busy      = (state_q == ST_RUN);
  assign WG_Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 image: an image-array model
// predicts every window, plus literal windows for the main scenarios.
module tb_window_gen_3x3;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WD = 9 * DW;

  logic          WG_Clk = 1'b0;
  logic          WG_Reset_InLow = 1'b0;
  logic          WG_Start = 1'b0;
  logic          WG_Pix_Valid = 1'b0;
  logic [DW-1:0] WG_Pix_Data = '0;
  logic          WG_Pix_Ready;
  logic          WG_Win_Valid;
  logic [WD-1:0] WG_Win_Data;
  logic          WG_Win_Ready = 1'b1;
  logic          WG_Busy;
  logic          WG_Done;

  int checks = 0;
  int failures = 0;

  window_gen_3x3 #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_WIDTH(3), .ROW_WIDTH(2)
  ) dut (
    .WG_Clk        (WG_Clk),
    .WG_Reset_InLow(WG_Reset_InLow),
    .WG_Start      (WG_Start),
    .WG_Pix_Valid  (WG_Pix_Valid),
    .WG_Pix_Data   (WG_Pix_Data),
    .WG_Pix_Ready  (WG_Pix_Ready),
    .WG_Win_Valid  (WG_Win_Valid),
    .WG_Win_Data   (WG_Win_Data),
    .WG_Win_Ready  (WG_Win_Ready),
    .WG_Busy       (WG_Busy),
    .WG_Done       (WG_Done)
  );

  always #5 WG_Clk = ~WG_Clk;

  task automatic checkOutput(input string name, input logic [WD-1:0] actual,
                             input logic [WD-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [WD-1:0] mkWin(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
    int v [9];
    logic [WD-1:0] w;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(v[i]);
    return w;
  endfunction

  // Model state: the frame as seen so far, the windows it implies, and the frame phase.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;
  logic [DW-1:0] img [H][W];
  logic [WD-1:0] expQ [$];
  logic [WD-1:0] winLog [$];
  int            phase = PH_IDLE;
  int            mr = 0, mc = 0;
  bit            pixelsDone = 0;
  bit            expectValidNext = 0;
  bit            prevStall = 0;
  logic [WD-1:0] prevData = '0;
  int            doneCount = 0;

  function automatic logic [WD-1:0] buildWin(input int r, input int c);
    logic [WD-1:0] w;
    for (int i = 0; i < 9; i++) w[DW*i +: DW] = img[r - 2 + i / 3][c - 2 + i % 3];
    return w;
  endfunction

  // Compare process: every falling edge, check outputs against the model, then
  // advance the model with whatever handshakes the coming rising edge will take.
  always @(negedge WG_Clk) begin
    int nextPhase;
    if (!WG_Reset_InLow) begin
      checkOutput("rstWinValid", WD'(WG_Win_Valid), '0);
      checkOutput("rstWinData", WG_Win_Data, '0);
      checkOutput("rstPixReady", WD'(WG_Pix_Ready), '0);
      checkOutput("rstBusy", WD'(WG_Busy), '0);
      checkOutput("rstDone", WD'(WG_Done), '0);
      phase = PH_IDLE; mr = 0; mc = 0; pixelsDone = 0;
      expQ.delete(); expectValidNext = 0; prevStall = 0;
    end else begin
      if (expectValidNext) checkOutput("winLatency", WD'(WG_Win_Valid), WD'(1));
      if (prevStall) begin
        checkOutput("stallValid", WD'(WG_Win_Valid), WD'(1));
        checkOutput("stallData", WG_Win_Data, prevData);
      end
      checkOutput("busy", WD'(WG_Busy), WD'(phase == PH_RUN));
      checkOutput("done", WD'(WG_Done), WD'(phase == PH_DONE));
      if (phase != PH_RUN) begin
        checkOutput("idlePixReady", WD'(WG_Pix_Ready), '0);
        checkOutput("idleWinValid", WD'(WG_Win_Valid), '0);
      end else if (WG_Win_Valid && !WG_Win_Ready) begin
        checkOutput("stallPixReady", WD'(WG_Pix_Ready), '0);
      end else if (pixelsDone) begin
        checkOutput("lastPixReady", WD'(WG_Pix_Ready), '0);
      end
      prevStall = WG_Win_Valid && !WG_Win_Ready;
      prevData = WG_Win_Data;
      expectValidNext = 0;
      nextPhase = phase;
      if (WG_Done) doneCount++;

      if (WG_Win_Valid && WG_Win_Ready) begin
        if (expQ.size() == 0) checkOutput("unexpectedWin", WD'(1), '0);
        else checkOutput("winData", WG_Win_Data, expQ.pop_front());
        winLog.push_back(WG_Win_Data);
        if (pixelsDone && expQ.size() == 0) nextPhase = PH_DONE;
      end

      if (phase == PH_RUN && WG_Pix_Valid && WG_Pix_Ready) begin
        img[mr][mc] = WG_Pix_Data;
        if (mr >= 2 && mc >= 2) begin
          expQ.push_back(buildWin(mr, mc));
          expectValidNext = 1;
        end
        if (mc == W - 1) begin
          mc = 0;
          if (mr == H - 1) pixelsDone = 1;
          else mr++;
        end else begin
          mc++;
        end
      end

      if (phase == PH_IDLE && WG_Start) begin
        nextPhase = PH_RUN; mr = 0; mc = 0; pixelsDone = 0;
      end else if (phase == PH_DONE) begin
        nextPhase = PH_IDLE;
      end
      phase = nextPhase;
    end
  end

  // Streams one frame of base+5r+c. Optional events keyed on the index of the
  // accepted pixel: stall the window side, abort with reset, or pulse WG_Start.
  task automatic applyStimulus(input int base, input int stallK, input int resetK,
                               input int startK);
    int  k = 0;
    int  budget = 0;
    int  waitCnt = 0;
    bit  acc;
    bit  startDone = 0;
    bit  aborted = 0;
    winLog.delete();
    doneCount = 0;
    @(posedge WG_Clk); #1 WG_Start = 1'b1;
    @(posedge WG_Clk); #1 WG_Start = 1'b0;
    while (k < W * H && budget < 200 && !aborted) begin
      WG_Pix_Valid = 1'b1;
      WG_Pix_Data  = DW'(base + 5 * (k / W) + k % W);
      WG_Start     = (k == startK) && !startDone;
      @(negedge WG_Clk);
      acc = WG_Pix_Valid && WG_Pix_Ready;
      @(posedge WG_Clk); #1;
      budget++;
      if (WG_Start) startDone = 1;
      WG_Start = 1'b0;
      if (acc) begin
        if (k == resetK) begin
          WG_Pix_Valid = 1'b0;
          WG_Reset_InLow = 1'b0;
          repeat (2) @(posedge WG_Clk);
          #1 WG_Reset_InLow = 1'b1;
          aborted = 1;
        end else if (k == stallK) begin
          k++;
          WG_Pix_Data  = DW'(base + 5 * (k / W) + k % W);
          WG_Win_Ready = 1'b0;
          repeat (5) @(posedge WG_Clk);
          #1 WG_Win_Ready = 1'b1;
        end else begin
          k++;
        end
      end
    end
    WG_Pix_Valid = 1'b0;
    if (!aborted) begin
      checkOutput("pixBudget", WD'(k), WD'(W * H));
      while (doneCount == 0 && waitCnt < 50) begin
        @(posedge WG_Clk);
        waitCnt++;
      end
      checkOutput("donePulseSeen", WD'(doneCount > 0), WD'(1));
      repeat (3) @(posedge WG_Clk);
      #1;
      checkOutput("donePulseCount", WD'(doneCount), WD'(1));
      checkOutput("idleAfterDone", WD'(WG_Busy), '0);
      checkOutput("modelQueueEmpty", WD'(expQ.size()), '0);
      checkOutput("winCount", WD'(winLog.size()), WD'(6));
    end
  endtask

  task automatic checkFrameLiterals(input string tag);
    if (winLog.size() == 6) begin
      checkOutput({tag, "FirstWin"}, winLog[0], mkWin(1, 2, 3, 6, 7, 8, 11, 12, 13));
      checkOutput({tag, "SecondWin"}, winLog[1], mkWin(2, 3, 4, 7, 8, 9, 12, 13, 14));
      checkOutput({tag, "RowWrapWin"}, winLog[3], mkWin(6, 7, 8, 11, 12, 13, 16, 17, 18));
      checkOutput({tag, "LastWin"}, winLog[5], mkWin(8, 9, 10, 13, 14, 15, 18, 19, 20));
    end
  endtask

  initial begin
    // Reset, then offer pixels while idle: none may be taken.
    repeat (3) @(posedge WG_Clk);
    #1 WG_Reset_InLow = 1'b1;
    WG_Pix_Valid = 1'b1;
    WG_Pix_Data  = 16'd77;
    repeat (5) @(posedge WG_Clk);
    #1 WG_Pix_Valid = 1'b0;
    checkOutput("idleNoWin", WD'(winLog.size()), '0);

    $display("[TB] normal frame");
    applyStimulus(1, -1, -1, -1);
    checkFrameLiterals("normal");

    $display("[TB] window-side stall frame");
    applyStimulus(1, 13, -1, -1);
    checkFrameLiterals("stall");

    $display("[TB] reset mid-frame, then fresh frame");
    applyStimulus(1, -1, 13, -1);
    applyStimulus(100, -1, -1, -1);
    if (winLog.size() > 0)
      checkOutput("afterResetFirstWin", winLog[0],
                  mkWin(100, 101, 102, 105, 106, 107, 110, 111, 112));

    $display("[TB] start pulsed during run");
    applyStimulus(1, -1, -1, 7);
    checkFrameLiterals("restart");

    repeat (3) @(posedge WG_Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
